clint_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the CLINT timer block. It shares the CLINT register interface between the core load/store path (port 0) and the difftest/debug access path (port 1), using round-robin grant. For each granted access it decodes the address, issues a single-cycle CLINT read or write strobe, and waits for the CLINT's registered read data or its MTIMECMP write-done pulse. It returns a one-cycle acknowledge, with a timeout and error report, to the granted requester.

---
 rtl/clint_arbiter_pkg.sv | 22 ++
 rtl/clint_rr_arb.sv | 15 +
 rtl/clint_arbiter.sv | 136 +++++++++++++
 tb/tb_clint_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_arbiter_pkg.sv
// Shared constants, state encoding and address decode for the CLINT front-end arbiter.
package clint_arbiter_pkg;

  localparam int          WORD_W        = 64;
  localparam logic        RST_ENABLE    = 1'b1;
  localparam logic [63:0] ZERO_WORD     = 64'h0;
  localparam logic [63:0] MTIME_ADDR    = 64'h0000_0000_0200_bff8;
  localparam logic [63:0] MTIMECMP_ADDR = 64'h0000_0000_0200_4000;

  typedef enum logic [1:0] {
    CARB_IDLE  = 2'd0,
    CARB_ISSUE = 2'd1,
    CARB_WAIT  = 2'd2,
    CARB_RESP  = 2'd3
  } carb_state_e;

  // Exact full-width match; the CLINT exposes only these two registers.
  function automatic logic addr_ok(input logic [WORD_W-1:0] a);
    return (a == MTIME_ADDR) || (a == MTIMECMP_ADDR);
  endfunction

endpackage

// File: rtl/clint_rr_arb.sv
// Two-way round-robin picker; the `last` register lives in the parent.
module clint_rr_arb (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = |req;
    // With both requesting, the port that was not served last wins.
    gnt_id    = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/clint_arbiter.sv
// Arbitrates two requesters onto the CLINT register port and sequences one access per grant.
// Handshake: req is held until ack; ack is a one-cycle one-hot pulse with err/rdata valid alongside it.
module clint_arbiter
  import clint_arbiter_pkg::*;
#(
  parameter int WR_TIMEOUT = 4
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [WORD_W-1:0] addr0,
  input  logic [WORD_W-1:0] addr1,
  input  logic [WORD_W-1:0] wdata0,
  input  logic [WORD_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic              err,
  output logic [WORD_W-1:0] rdata,
  output logic              read_en,
  output logic [WORD_W-1:0] read_addr,
  output logic              write_en,
  output logic [WORD_W-1:0] write_addr,
  output logic [WORD_W-1:0] data_write,
  input  logic [WORD_W-1:0] data_read,
  input  logic              clint_write_isdone,
  output logic [1:0]        dbg_state
);

  localparam logic [2:0] TO_LAST = 3'(WR_TIMEOUT - 1);

  carb_state_e       state, state_nx;
  logic              last;
  logic [2:0]        cnt;
  logic              id_q;
  logic              we_q;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              err_q;
  logic [WORD_W-1:0] rdata_q;

  logic              gnt_valid;
  logic              gnt_id;
  logic [WORD_W-1:0] sel_addr;
  logic [WORD_W-1:0] sel_wdata;

  clint_rr_arb u_rr (
    .req       (req),
    .last      (last),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign sel_addr  = gnt_id ? addr1  : addr0;
  assign sel_wdata = gnt_id ? wdata1 : wdata0;
  assign dbg_state = state;

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst_n == RST_ENABLE) begin
      state   <= CARB_IDLE;
      last    <= 1'b1;
      cnt     <= 3'd0;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= ZERO_WORD;
      wdata_q <= ZERO_WORD;
      err_q   <= 1'b0;
      rdata_q <= ZERO_WORD;
    end else begin
      state <= state_nx;
      case (state)
        CARB_IDLE: begin
          if (gnt_valid) begin
            id_q    <= gnt_id;
            last    <= gnt_id;
            we_q    <= we[gnt_id];
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            err_q   <= ~addr_ok(sel_addr);
            rdata_q <= ZERO_WORD;
          end
        end
        CARB_ISSUE: cnt <= 3'd0;
        CARB_WAIT: begin
          if (!we_q) begin
            rdata_q <= data_read;
          end else if (!clint_write_isdone) begin
            cnt <= cnt + 3'd1;
            if (cnt == TO_LAST) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      CARB_IDLE:  if (gnt_valid) state_nx = addr_ok(sel_addr) ? CARB_ISSUE : CARB_RESP;
      // MTIME writes get no done pulse, so they skip WAIT.
      CARB_ISSUE: state_nx = (we_q && addr_q == MTIME_ADDR) ? CARB_RESP : CARB_WAIT;
      CARB_WAIT: begin
        if (!we_q || clint_write_isdone || cnt == TO_LAST) state_nx = CARB_RESP;
      end
      CARB_RESP:  state_nx = CARB_IDLE;
      default:    state_nx = CARB_IDLE;
    endcase
  end

  always_comb begin
    ack        = 2'b00;
    err        = 1'b0;
    rdata      = ZERO_WORD;
    read_en    = 1'b0;
    read_addr  = ZERO_WORD;
    write_en   = 1'b0;
    write_addr = ZERO_WORD;
    data_write = ZERO_WORD;
    if (state == CARB_ISSUE) begin
      if (we_q) begin
        write_en   = 1'b1;
        write_addr = addr_q;
        data_write = wdata_q;
      end else begin
        read_en   = 1'b1;
        read_addr = addr_q;
      end
    end
    if (state == CARB_RESP) begin
      ack[id_q] = 1'b1;
      err       = err_q;
      rdata     = rdata_q;
    end
  end

endmodule

// File: tb/tb_clint_arbiter.sv
// Randomized scoreboard bench for clint_arbiter with a behavioural CLINT and arbitration model.
module tb_clint_arbiter;
  import clint_arbiter_pkg::*;

  localparam int WR_TIMEOUT = 4;
  localparam int EW = 32 + 2 + 1 + 64;       // {cycle, ack, err, rdata}
  localparam int SW = 32 + 1 + 1 + 64 + 64;  // {cycle, read_en, write_en, addr, data}

  logic        clk;
  logic        rst;
  logic [1:0]  req, we, ack;
  logic [63:0] addr0, addr1, wdata0, wdata1, rdata;
  logic        err, read_en, write_en, clint_write_isdone;
  logic [63:0] read_addr, write_addr, data_write, data_read;
  logic [1:0]  dbg_state;

  logic [EW-1:0] exp_q[$];
  logic [SW-1:0] st_q[$];
  int          checks, errors, cyc;
  logic [63:0] rd_val;
  bit          suppress;
  bit          model_last;

  clint_arbiter #(.WR_TIMEOUT(WR_TIMEOUT)) dut (
    .cpu_clk_50M        (clk),
    .cpu_rst_n          (rst),
    .req                (req),
    .we                 (we),
    .addr0              (addr0),
    .addr1              (addr1),
    .wdata0             (wdata0),
    .wdata1             (wdata1),
    .ack                (ack),
    .err                (err),
    .rdata              (rdata),
    .read_en            (read_en),
    .read_addr          (read_addr),
    .write_en           (write_en),
    .write_addr         (write_addr),
    .data_write         (data_write),
    .data_read          (data_read),
    .clint_write_isdone (clint_write_isdone),
    .dbg_state          (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // CLINT model: registered read data, done pulse one cycle after an MTIMECMP write
  always @(posedge clk) begin
    data_read          <= read_en ? rd_val : {$urandom, $urandom};
    clint_write_isdone <= write_en && (write_addr == MTIMECMP_ADDR) && !suppress;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst == 1'b0) begin
      logic [EW-1:0] e;
      logic [SW-1:0] s;
      if (ack != 2'b00) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: ack=%b at cycle %0d", ack, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e !== {32'(cyc), ack, err, rdata}) begin
            errors++;
            $display("FAIL ack_pkt: got cyc=%0d ack=%b err=%b rdata=%h expected cyc=%0d ack=%b err=%b rdata=%h",
                     cyc, ack, err, rdata, e[EW-1 -: 32], e[66:65], e[64], e[63:0]);
          end
        end
      end else begin
        checks++;
        if (err !== 1'b0) begin
          errors++;
          $display("FAIL err_idle: got err=%b expected 0 at cycle %0d", err, cyc);
        end
      end
      if (read_en || write_en) begin
        checks++;
        if (st_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: re=%b we=%b at cycle %0d", read_en, write_en, cyc);
        end else begin
          s = st_q.pop_front();
          if (s !== {32'(cyc), read_en, write_en, (read_en ? read_addr : write_addr),
                     (write_en ? data_write : 64'h0)}) begin
            errors++;
            $display("FAIL strobe: got cyc=%0d re=%b we=%b ra=%h wa=%h wd=%h expected cyc=%0d re=%b we=%b a=%h d=%h",
                     cyc, read_en, write_en, read_addr, write_addr, data_write,
                     s[SW-1 -: 32], s[129], s[128], s[127:64], s[63:0]);
          end
        end
      end
    end
  end

  // expected response from the spec rules; k is the cycle whose closing edge samples req
  task automatic push_exp(input int p, input bit w, input logic [63:0] a, input logic [63:0] d, input int k);
    bit ok;
    int lat;
    bit e;
    logic [63:0] rd;
    logic [1:0] oh;
    ok = (a == MTIME_ADDR) || (a == MTIMECMP_ADDR);
    e = 1'b0;
    rd = 64'h0;
    if (!ok) begin
      lat = 1; e = 1'b1;
    end else if (!w) begin
      lat = 3; rd = rd_val;
    end else if (a == MTIME_ADDR) begin
      lat = 2;
    end else if (suppress) begin
      lat = 2 + WR_TIMEOUT; e = 1'b1;
    end else begin
      lat = 3;
    end
    oh = (p == 1) ? 2'b10 : 2'b01;
    exp_q.push_back({32'(k + lat), oh, e, rd});
    if (ok) st_q.push_back({32'(k + 1), !w, w, a, (w ? d : 64'h0)});
    model_last = (p == 1);
  endtask

  task automatic wait_ack(output int c);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == 2'b00 && n < 40);
    checks++;
    if (ack == 2'b00) begin
      errors++;
      $display("FAIL ack_timeout: no ack within %0d cycles", n);
    end
    c = cyc;
  endtask

  // driver: one transaction from a single port, called at a negedge with the DUT idle
  task automatic run_txn(input int p, input bit w, input logic [63:0] a, input logic [63:0] d, input bit sup);
    int c;
    rd_val   = {$urandom, $urandom};
    suppress = sup;
    if (p == 0) begin
      addr0 = a; wdata0 = d; addr1 = {$urandom, $urandom};
    end else begin
      addr1 = a; wdata1 = d; addr0 = {$urandom, $urandom};
    end
    we[p]  = w;
    req[p] = 1'b1;
    push_exp(p, w, a, d, cyc);
    wait_ack(c);
    req[p] = 1'b0;
    @(negedge clk);
  endtask

  // both ports hold read requests; the model predicts each winner
  task automatic run_pair(input int n);
    int k, c, win;
    addr0 = MTIME_ADDR; addr1 = MTIME_ADDR;
    we = 2'b00;
    req = 2'b11;
    suppress = 1'b0;
    k = cyc;
    for (int i = 0; i < n; i++) begin
      rd_val = {$urandom, $urandom};
      win = model_last ? 0 : 1;
      push_exp(win, 1'b0, MTIME_ADDR, 64'h0, k);
      wait_ack(c);
      k = c + 1;
    end
    req = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    int c, op, p;
    logic [63:0] bad;
    checks = 0; errors = 0; cyc = 0;
    rst = 1'b1; req = 2'b00; we = 2'b00;
    addr0 = 64'h0; addr1 = 64'h0; wdata0 = 64'h0; wdata1 = 64'h0;
    rd_val = 64'h0; suppress = 1'b0; model_last = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ack", {62'h0, ack}, 64'h0);
    check("rst_err", {63'h0, err}, 64'h0);
    check("rst_rdata", rdata, 64'h0);
    check("rst_strobes", {62'h0, read_en, write_en}, 64'h0);
    check("rst_addrs", read_addr | write_addr | data_write, 64'h0);
    check("rst_state", {62'h0, dbg_state}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // directed cases
    run_txn(0, 1'b0, MTIME_ADDR, 64'h0, 1'b0);
    run_txn(1, 1'b1, MTIMECMP_ADDR, 64'h100, 1'b0);
    run_txn(0, 1'b1, MTIME_ADDR, 64'hdead_beef, 1'b0);
    run_txn(1, 1'b0, 64'h0, 64'h0, 1'b0);
    run_txn(0, 1'b1, MTIMECMP_ADDR, 64'h55, 1'b1);
    run_pair(4);

    // reset while waiting on a read
    rd_val = {$urandom, $urandom};
    addr0 = MTIME_ADDR; we[0] = 1'b0; req[0] = 1'b1;
    st_q.push_back({32'(cyc + 1), 1'b1, 1'b0, MTIME_ADDR, 64'h0});
    repeat (2) @(negedge clk);
    check("pre_rst_state", {62'h0, dbg_state}, {62'h0, CARB_WAIT});
    rst = 1'b1; req = 2'b00;
    @(negedge clk);
    check("wait_rst_state", {62'h0, dbg_state}, 64'h0);
    check("wait_rst_ack", {62'h0, ack}, 64'h0);
    check("wait_rst_outs", rdata | read_addr | write_addr | data_write, 64'h0);
    check("wait_rst_strobes", {62'h0, read_en, write_en}, 64'h0);
    rst = 1'b0;
    model_last = 1'b1;
    @(negedge clk);
    run_txn(1, 1'b0, MTIMECMP_ADDR, 64'h0, 1'b0);
    run_pair(2);

    // random single-port traffic
    for (int i = 0; i < 30; i++) begin
      p  = $urandom_range(0, 1);
      op = $urandom_range(0, 5);
      bad = MTIME_ADDR ^ (64'h1 << $urandom_range(0, 63));
      case (op)
        0: run_txn(p, 1'b0, MTIME_ADDR, 64'h0, 1'b0);
        1: run_txn(p, 1'b0, MTIMECMP_ADDR, 64'h0, 1'b0);
        2: run_txn(p, 1'b1, MTIME_ADDR, {$urandom, $urandom}, 1'b0);
        3: run_txn(p, 1'b1, MTIMECMP_ADDR, {$urandom, $urandom}, 1'b0);
        4: run_txn(p, 1'b1, MTIMECMP_ADDR, {$urandom, $urandom}, 1'b1);
        default: run_txn(p, 1'($urandom_range(0, 1)), bad, {$urandom, $urandom}, 1'b0);
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    if ($urandom_range(0, 1) == 1) run_pair(3);

    repeat (4) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'h0);
    check("st_q_drained", 64'(st_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
